// File: rtl/adc_readout_scheduler.sv
// adc_readout_scheduler
// Buffers one sample per ADC channel and grants the pending channels
// round-robin onto a single valid/ready stream for the serial line formatter.
// Drops are reported per channel through sticky overrun flags.
//
// Optional build macro ADC_SCHED_OVERRUN_CNT_EN adds the overrun_count port,
// a saturating 8-bit drop counter per channel.
//
// CH_W must equal clog2(NUM_CH), with a minimum of 1.

module adc_readout_scheduler #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic [NUM_CH-1:0]        adc_data_enable,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_channel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        pending,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clear
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]      overrun_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                state_q;
    logic [DATA_W-1:0]     out_data_q;
    logic [CH_W-1:0]       out_channel_q;
    logic                  out_valid_q;
    logic [CH_W-1:0]       last_grant_q;

    logic [NUM_CH-1:0]     enable_q;
    logic [NUM_CH-1:0]     pending_q;
    logic [NUM_CH-1:0]     pending_d;
    logic [NUM_CH-1:0]     overrun_q;
    logic [NUM_CH-1:0]     overrun_d;
    logic [DATA_W-1:0]     slot_q [NUM_CH];

    logic [NUM_CH-1:0]     capture;
    logic [NUM_CH-1:0]     unload;
    logic [NUM_CH-1:0]     store;
    logic [NUM_CH-1:0]     drop;
    logic                  grant;
    logic                  found;
    logic [CH_W-1:0]       sel;

    // Round-robin pick: first pending channel above last_grant, else wrap to the lowest.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        found = 1'b0;
        sel   = last_grant_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending_q[i] && (i > int'(last_grant_q))) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending_q[i] && (i <= int'(last_grant_q))) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
    end

    // Edge detect, slot unload, capture/drop decisions and next flag values.
    always_comb begin
        grant   = (state_q == IDLE) && (|pending_q);
        capture = adc_data_enable & ~enable_q;
        unload  = '0;
        drop    = '0;
        store   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            unload[i] = grant && (sel == CH_W'(i));
            // A slot being unloaded this cycle can accept the new sample.
            drop[i]   = capture[i] && pending_q[i] && !unload[i];
            store[i]  = capture[i] && !drop[i];
        end
        // A capture on the slot being granted sets pending again.
        pending_d = (pending_q & ~unload) | store;
        // A drop in the same cycle as a clear leaves its flag set.
        overrun_d = (overrun_clear ? '0 : overrun_q) | drop;
    end

    // Output FSM: load the granted slot in IDLE, hold it in OFFER until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            last_grant_q  <= LAST_CH;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        out_data_q    <= slot_q[sel];
                        out_channel_q <= sel;
                        out_valid_q   <= 1'b1;
                        last_grant_q  <= sel;
                        state_q       <= OFFER;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Enable history and the per-channel pending and overrun flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            enable_q  <= adc_data_enable;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Sample slots: written on an accepted capture.
    // NOTE: the slot storage has no reset; a slot is only read while its pending flag is set, and that flag is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (store[i]) begin
                slot_q[i] <= adc_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ADC_SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q [NUM_CH];

    // Saturating drop counters; a drop alongside a clear restarts the count at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ovr_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (overrun_clear) begin
                    ovr_cnt_q[i] <= {7'd0, drop[i]};
                end else if (drop[i] && (ovr_cnt_q[i] != 8'hFF)) begin
                    ovr_cnt_q[i] <= ovr_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Pack the counters onto the flat output port.
    always_comb begin
        overrun_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            overrun_count[i*8 +: 8] = ovr_cnt_q[i];
        end
    end
`endif

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/adc_readout_scheduler.md
Name: adc_readout_scheduler

Overview:
- Collects samples from NUM_CH ADC channels. Each channel has its own data bus and data-enable strobe.
- Buffers one sample per channel and grants channels round-robin onto a single valid/ready stream. The stream feeds the serial line formatter.
- Sits between the ADC capture front-ends and the serializer. It replaces per-channel priority logic with fair sharing and reports sample drops (overrun).

Parameters:
- NUM_CH, 2, number of ADC channels (2..8).
- DATA_W, 16, sample width in bits.
- CH_W, 1, channel index width; must equal clog2(NUM_CH), minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- adc_data  input  NUM_CH*DATA_W  channel i sample in bits [i*DATA_W +: DATA_W].
- adc_data_enable  input  NUM_CH  per-channel strobe; a rising edge means a new sample is valid.
- out_data  output  DATA_W  granted sample.
- out_channel  output  CH_W  index of the granted channel.
- out_valid  output  1  out_data/out_channel valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- pending  output  NUM_CH  channel slot holds an unsent sample.
- overrun  output  NUM_CH  sticky flag: a sample was dropped on that channel.
- overrun_clear  input  1  synchronous clear of all overrun flags.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - out_valid=0, out_data=0, out_channel=0, pending=0, overrun=0.
  - Enable history register = 0; last_grant = NUM_CH-1; state = IDLE.
- Edge detect:
  - Capture event on channel i = adc_data_enable[i] && !enable_d[i], with enable_d registered every cycle.
  - An enable already high when reset releases is captured once.
- Capture:
  - If slot i is free, or is being unloaded in the same cycle, latch the data into slot i and set pending[i].
  - If slot i is pending and not being unloaded, drop the new sample, keep the old one, and set overrun[i].
- State IDLE:
  - If any pending bit is set, select the first pending channel scanning from last_grant+1 upward with wrap-around.
  - Register out_data from that slot, out_channel = index, out_valid = 1, clear pending[sel], last_grant = sel, go to OFFER.
  - A capture on sel in the same cycle wins: pending[sel] stays 1 with the new data.
- State OFFER:
  - out_valid, out_data and out_channel are held stable while out_ready = 0.
  - On out_ready = 1: out_valid = 0, go to IDLE.
- Latency: a capture edge sampled at clock edge k gives pending high after edge k and out_valid high after edge k+1.
- Throughput: at most one transfer every 2 cycles.
- overrun_clear clears all flags. An overrun event on the same cycle wins and leaves that flag set.
- out_valid never drops without a handshake, except on reset.

Optional Feature:
- ADC_SCHED_OVERRUN_CNT_EN defined:
  - Adds output port overrun_count, NUM_CH*8 bits: a per-channel 8-bit counter of dropped samples.
  - Counters saturate at 255, are cleared by overrun_clear (a same-cycle drop counts as 1), and reset to 0.
- Not defined: port and counters absent; only the sticky flags exist.

Test Plan:
- Single sample: ch0 edge with adc_data 0x1234, out_ready=1 -> out_valid high 2 cycles after the edge sample, out_data=0x1234, out_channel=0, high for exactly 1 cycle; pending returns to 0.
- Fairness: after reset, simultaneous edges ch0=0xAAAA and ch1=0x5555 -> ch0 granted first, then ch1. Repeat the simultaneous edges -> ch0 then ch1 again, since last_grant=1.
- Backpressure: out_ready=0 for 10 cycles during OFFER -> out_valid, out_data and out_channel constant. out_ready=1 -> exactly one transfer.
- Overrun: out_ready=0, then ch1 edges with 0x1111, 0x2222, 0x3333 -> overrun[1]=1. After out_ready=1, the deliveries are 0x1111 then 0x2222; 0x3333 is never delivered. overrun_clear -> overrun[1]=0.
- Reset mid-OFFER: assert reset while out_valid=1 -> out_valid, pending and overrun go to 0 immediately. After release, a held-high enable is captured once.
- Feature on: 300 overrun drops on ch0 -> overrun_count[7:0]=255. overrun_clear -> 0.
